slice_queue: RTL and testbench

SLICE_QUEUE -- requirements
Module: slice_queue

---
 rtl/slice_pkg.sv | 20 ++
 rtl/slice_queue_ram.sv | 24 ++
 rtl/slice_queue.sv | 139 +++++++++++++
 tb/tb_slice_queue.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/slice_pkg.sv
// Shared slice record definitions for the queue, distributor and parsers.
package slice_pkg;

   localparam int DATA_W = 144;
   localparam int POS_W  = 16;
   localparam int ADDR_W = 17;
   localparam int GARB_W = 3;
   localparam int LIT_W  = 1;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [POS_W-1:0]  position;
      logic [ADDR_W-1:0] address;
      logic [GARB_W-1:0] garbage;
      logic [LIT_W-1:0]  lit_flag;
   } slice_t;

   localparam int SLICE_W = $bits(slice_t);

endpackage

// File: rtl/slice_queue_ram.sv
// Simple dual-port slice storage: one write port, one registered read port.
module slice_queue_ram #(
   parameter int AW = 4,
   parameter int W  = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rd_data
);

   logic [W-1:0] mem_q [0:(1<<AW)-1];
   logic [W-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
      rd_data_q <= mem_q[raddr];
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/slice_queue.sv
// Show-ahead slice FIFO with registered-read storage and write bypass.
// Optional statistics outputs enabled by SLICE_QUEUE_STATS_EN.
module slice_queue
   import slice_pkg::*;
#(
   parameter int DEPTH_LOG2  = 4,
   parameter int AFULL_LEVEL = 12
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wrreq,
   input  logic [DATA_W-1:0]   data_in,
   input  logic [POS_W-1:0]    position_in,
   input  logic [ADDR_W-1:0]   address_in,
   input  logic [GARB_W-1:0]   garbage_in,
   input  logic [LIT_W-1:0]    lit_flag_in,
   output logic                almost_full,
   input  logic                rdreq,
   output logic                valid_out,
   output logic [DATA_W-1:0]   data_out,
   output logic [POS_W-1:0]    position_out,
   output logic [ADDR_W-1:0]   address_out,
   output logic [GARB_W-1:0]   garbage_out,
   output logic [LIT_W-1:0]    lit_flag_out,
`ifdef SLICE_QUEUE_STATS_EN
   output logic [15:0]         push_cnt,
   output logic [15:0]         pop_cnt,
   output logic                overflow,
`endif
   output logic [DEPTH_LOG2:0] usedw
);

   localparam int CW = DEPTH_LOG2 + 1;
   localparam logic [CW-1:0] FULL_CNT  = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LEVEL);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  valid_q, valid_d;
   logic                  afull_q, afull_d;
   logic                  byp_q, byp_d;
   slice_t                byp_data_q;
   slice_t                wr_slice, ram_slice, head;
   logic                  push, pop;

   assign wr_slice = '{data: data_in, position: position_in,
                       address: address_in, garbage: garbage_in,
                       lit_flag: lit_flag_in};

   always_comb begin
      pop      = rdreq & valid_q;
      push     = wrreq & ((count_q != FULL_CNT) | pop);
      wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop) count_d = count_q + CNT_ONE;
      if (pop && !push) count_d = count_q - CNT_ONE;
      valid_d  = (count_d != '0);
      afull_d  = (count_d >= AFULL_CNT);
      // A write landing on the next head address misses the RAM read
      byp_d    = push & (wr_ptr_q == rd_ptr_d);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
         afull_q  <= 1'b0;
         byp_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
         afull_q  <= afull_d;
         byp_q    <= byp_d;
      end
   end

   always_ff @(posedge clk) begin
      if (byp_d) byp_data_q <= wr_slice;
   end

   slice_queue_ram #(
      .AW (DEPTH_LOG2),
      .W  (SLICE_W)
   ) u_ram (
      .clk     (clk),
      .we      (push & rst_n),
      .waddr   (wr_ptr_q),
      .wdata   (wr_slice),
      .raddr   (rd_ptr_d),
      .rd_data (ram_slice)
   );

   assign head         = byp_q ? byp_data_q : ram_slice;
   assign valid_out    = valid_q;
   assign almost_full  = afull_q;
   assign usedw        = count_q;
   assign data_out     = head.data;
   assign position_out = head.position;
   assign address_out  = head.address;
   assign garbage_out  = head.garbage;
   assign lit_flag_out = head.lit_flag;

`ifdef SLICE_QUEUE_STATS_EN
   logic [15:0] push_cnt_q, push_cnt_d;
   logic [15:0] pop_cnt_q, pop_cnt_d;
   logic        ovf_q, ovf_d;

   always_comb begin
      push_cnt_d = push ? push_cnt_q + 16'd1 : push_cnt_q;
      pop_cnt_d  = pop ? pop_cnt_q + 16'd1 : pop_cnt_q;
      ovf_d      = ovf_q | (wrreq & ~push);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         push_cnt_q <= '0;
         pop_cnt_q  <= '0;
         ovf_q      <= 1'b0;
      end else begin
         push_cnt_q <= push_cnt_d;
         pop_cnt_q  <= pop_cnt_d;
         ovf_q      <= ovf_d;
      end
   end

   assign push_cnt = push_cnt_q;
   assign pop_cnt  = pop_cnt_q;
   assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_slice_queue.sv
// Randomized and directed bench for slice_queue against a queue model.
// Statistics checks follow SLICE_QUEUE_STATS_EN.
module tb_slice_queue;
   import slice_pkg::*;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               wrreq, rdreq;
   logic [DATA_W-1:0]  data_in;
   logic [POS_W-1:0]   position_in;
   logic [ADDR_W-1:0]  address_in;
   logic [GARB_W-1:0]  garbage_in;
   logic [LIT_W-1:0]   lit_flag_in;
   logic               almost_full, valid_out;
   logic [DATA_W-1:0]  data_out;
   logic [POS_W-1:0]   position_out;
   logic [ADDR_W-1:0]  address_out;
   logic [GARB_W-1:0]  garbage_out;
   logic [LIT_W-1:0]   lit_flag_out;
   logic [4:0]         usedw;
`ifdef SLICE_QUEUE_STATS_EN
   logic [15:0]        push_cnt, pop_cnt;
   logic               overflow;
`endif

   int n_checks = 0;
   int n_errors = 0;

   slice_t mq[$];
   int     m_push = 0;
   int     m_pop  = 0;
   bit     m_ovf  = 1'b0;

   always #5 clk = ~clk;

   slice_queue dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wrreq        (wrreq),
      .data_in      (data_in),
      .position_in  (position_in),
      .address_in   (address_in),
      .garbage_in   (garbage_in),
      .lit_flag_in  (lit_flag_in),
      .almost_full  (almost_full),
      .rdreq        (rdreq),
      .valid_out    (valid_out),
      .data_out     (data_out),
      .position_out (position_out),
      .address_out  (address_out),
      .garbage_out  (garbage_out),
      .lit_flag_out (lit_flag_out),
`ifdef SLICE_QUEUE_STATS_EN
      .push_cnt     (push_cnt),
      .pop_cnt      (pop_cnt),
      .overflow     (overflow),
`endif
      .usedw        (usedw)
   );

   task automatic check(input string tag, input logic [191:0] got,
                        input logic [191:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic slice_t rand_slice();
      slice_t s;
      s.data     = {$urandom(), $urandom(), $urandom(), $urandom(),
                    16'($urandom())};
      s.position = 16'($urandom());
      s.address  = 17'($urandom());
      s.garbage  = 3'($urandom());
      s.lit_flag = 1'($urandom());
      return s;
   endfunction

   task automatic check_outputs();
      slice_t got;
      got = '{data: data_out, position: position_out,
              address: address_out, garbage: garbage_out,
              lit_flag: lit_flag_out};
      check("valid_out", 192'(valid_out), 192'(mq.size() != 0));
      check("usedw", 192'(usedw), 192'(mq.size()));
      check("almost_full", 192'(almost_full), 192'(mq.size() >= 12));
      if (mq.size() != 0) check("head", 192'(got), 192'(mq[0]));
`ifdef SLICE_QUEUE_STATS_EN
      check("push_cnt", 192'(push_cnt), 192'(16'(m_push)));
      check("pop_cnt", 192'(pop_cnt), 192'(16'(m_pop)));
      check("overflow", 192'(overflow), 192'(m_ovf));
`endif
   endtask

   // Check current state, apply one cycle of stimulus, advance the model.
   task automatic cyc(input bit w, input bit r, input bit rv,
                      input slice_t s);
      bit pop_ok, push_ok;
      check_outputs();
      wrreq       = w;
      rdreq       = r;
      rst_n       = rv;
      data_in     = s.data;
      position_in = s.position;
      address_in  = s.address;
      garbage_in  = s.garbage;
      lit_flag_in = s.lit_flag;
      @(posedge clk);
      if (!rv) begin
         mq.delete();
         m_push = 0;
         m_pop  = 0;
         m_ovf  = 1'b0;
      end else begin
         pop_ok  = r && (mq.size() > 0);
         push_ok = w && (mq.size() < 16 || pop_ok);
         if (pop_ok) begin
            void'(mq.pop_front());
            m_pop++;
         end
         if (push_ok) begin
            mq.push_back(s);
            m_push++;
         end
         if (w && !push_ok) m_ovf = 1'b1;
      end
      @(negedge clk);
   endtask

   initial begin
      slice_t s0;
      rst_n = 1'b0;
      wrreq = 1'b0;
      rdreq = 1'b0;
      data_in = '0;
      position_in = '0;
      address_in = '0;
      garbage_in = '0;
      lit_flag_in = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);

      // single push with known fields
      s0 = '{data: 144'hA5, position: 16'h0010, address: 17'h00123,
             garbage: 3'd0, lit_flag: 1'b0};
      cyc(1, 0, 1, s0);
      check("first_usedw", 192'(usedw), 192'(1));
      check("first_data", 192'(data_out), 192'(144'hA5));
      cyc(0, 1, 1, rand_slice());

      // fill past full; the 17th push is dropped
      for (int i = 0; i < 17; i++) cyc(1, 0, 1, rand_slice());
      check("full_usedw", 192'(usedw), 192'(16));
      // push and pop together while full
      cyc(1, 1, 1, rand_slice());
      for (int i = 0; i < 18; i++) cyc(0, 1, 1, rand_slice());

      // push and pop together while empty: pop ignored
      cyc(1, 1, 1, rand_slice());
      check("empty_rw_usedw", 192'(usedw), 192'(1));
      cyc(0, 1, 1, rand_slice());

      // random traffic across pointer wraps
      for (int i = 0; i < 400; i++)
         cyc(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 50),
             1, rand_slice());
      for (int i = 0; i < 18; i++) cyc(0, 1, 1, rand_slice());

      // reset mid-operation with nine entries stored
      for (int i = 0; i < 9; i++) cyc(1, 0, 1, rand_slice());
      check("pre_reset_usedw", 192'(usedw), 192'(9));
      cyc(1, 1, 0, rand_slice());
      check("rst_usedw", 192'(usedw), 192'(0));
      check("rst_valid", 192'(valid_out), 192'(0));
      check("rst_afull", 192'(almost_full), 192'(0));
      for (int i = 0; i < 60; i++)
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1,
             rand_slice());
      check_outputs();

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
